// File: rtl/winker_blink_driver.sv
// ============================================================================
// Module   : winker_blink_driver
// Purpose  : Turns the winker mode requests into a blinking lamp drive.
//            Requests are levels from the upstream mode FSM. A blink sequence
//            cycles through the ON and OFF states, each HALF_PERIOD clocks
//            long. The block produces a clicker tick at each lamp rise and
//            counts the completed ON phases.
// Config   : `define WINKER_HAZARD_EN adds hazard support. With it, both
//            requests high latch side BOTH and both lamps blink in phase.
//            Without it, the left request wins.
// Ports    : clk          - single clock, all state updates on posedge
//            reset_n      - asynchronous active-low reset
//            i_left_req   - left winker mode request (level)
//            i_right_req  - right winker mode request (level)
//            o_left_lamp  - registered left lamp drive
//            o_right_lamp - registered right lamp drive
//            o_tick       - registered one-cycle pulse at every ON entry
//            o_blink_cnt  - completed ON phases in the current sequence,
//                           saturating
//            o_busy       - high while not IDLE
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module winker_blink_driver #(
  parameter int HALF_PERIOD = 4,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_left_req,
  input  logic             i_right_req,
  output logic             o_left_lamp,
  output logic             o_right_lamp,
  output logic             o_tick,
  output logic [CNT_W-1:0] o_blink_cnt,
  output logic             o_busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ON   = 2'd1;
  localparam logic [1:0] ST_OFF  = 2'd2;

`ifdef WINKER_HAZARD_EN
  localparam int SW = 2;
`else
  localparam int SW = 1;
`endif
  localparam logic [SW-1:0] SIDE_LEFT  = SW'(0);
  localparam logic [SW-1:0] SIDE_RIGHT = SW'(1);
`ifdef WINKER_HAZARD_EN
  localparam logic [SW-1:0] SIDE_BOTH  = SW'(2);
`endif

  localparam logic [15:0]      PHASE_LAST = 16'(HALF_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  logic [1:0]       state, state_nxt;
  logic [SW-1:0]    side, side_nxt;
  logic [15:0]      phase, phase_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             enter_on;
  logic             req_any;
  logic [SW-1:0]    req_side;
  logic             side_hi;
  logic             side_change;
  logic             phase_last;
  logic             left_lamp_nxt, right_lamp_nxt;

  assign req_any = i_left_req | i_right_req;

`ifdef WINKER_HAZARD_EN
  always_comb begin
    req_side = SIDE_LEFT;
    if (i_left_req && i_right_req) begin
      req_side = SIDE_BOTH;
    end else if (i_right_req) begin
      req_side = SIDE_RIGHT;
    end
  end

  always_comb begin
    case (side)
      SIDE_LEFT:  side_hi = i_left_req;
      SIDE_RIGHT: side_hi = i_right_req;
      default:    side_hi = i_left_req & i_right_req;
    endcase
  end
`else
  // Left wins when both are requested.
  assign req_side = i_left_req ? SIDE_LEFT : SIDE_RIGHT;
  assign side_hi  = (side == SIDE_LEFT) ? i_left_req : i_right_req;
`endif

  // A live request pointing to a different side restarts the sequence.
  // This also covers entry to and exit from BOTH.
  assign side_change = req_any && (req_side != side);
  assign phase_last  = (phase == PHASE_LAST);

  always_comb begin
    state_nxt = state;
    side_nxt  = side;
    phase_nxt = phase;
    cnt_nxt   = o_blink_cnt;
    enter_on  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_any) begin
          state_nxt = ST_ON;
          side_nxt  = req_side;
          phase_nxt = '0;
          cnt_nxt   = '0;
          enter_on  = 1'b1;
        end
      end
      ST_ON: begin
        if (side_change) begin
          side_nxt  = req_side;
          phase_nxt = '0;
          cnt_nxt   = '0;
          enter_on  = 1'b1;
        end else if (phase_last) begin
          // A dropped request still completes the ON phase and counts it.
          // The block then skips OFF and goes straight back to IDLE.
          state_nxt = side_hi ? ST_OFF : ST_IDLE;
          phase_nxt = '0;
          cnt_nxt   = (o_blink_cnt == CNT_MAX) ? o_blink_cnt
                                               : o_blink_cnt + CNT_W'(1);
        end else begin
          phase_nxt = phase + 16'd1;
        end
      end
      ST_OFF: begin
        if (side_change) begin
          state_nxt = ST_ON;
          side_nxt  = req_side;
          phase_nxt = '0;
          cnt_nxt   = '0;
          enter_on  = 1'b1;
        end else if (!side_hi) begin
          state_nxt = ST_IDLE;
          phase_nxt = '0;
        end else if (phase_last) begin
          state_nxt = ST_ON;
          phase_nxt = '0;
          enter_on  = 1'b1;
        end else begin
          phase_nxt = phase + 16'd1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        phase_nxt = '0;
      end
    endcase
  end

`ifdef WINKER_HAZARD_EN
  assign left_lamp_nxt  = (state_nxt == ST_ON) &&
                          ((side_nxt == SIDE_LEFT) || (side_nxt == SIDE_BOTH));
  assign right_lamp_nxt = (state_nxt == ST_ON) &&
                          ((side_nxt == SIDE_RIGHT) || (side_nxt == SIDE_BOTH));
`else
  assign left_lamp_nxt  = (state_nxt == ST_ON) && (side_nxt == SIDE_LEFT);
  assign right_lamp_nxt = (state_nxt == ST_ON) && (side_nxt == SIDE_RIGHT);
`endif

  // The outputs are registered from the next-state values, so they line up
  // with the state register without adding a cycle of latency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      side         <= SIDE_LEFT;
      phase        <= '0;
      o_blink_cnt  <= '0;
      o_left_lamp  <= 1'b0;
      o_right_lamp <= 1'b0;
      o_tick       <= 1'b0;
      o_busy       <= 1'b0;
    end else begin
      state        <= state_nxt;
      side         <= side_nxt;
      phase        <= phase_nxt;
      o_blink_cnt  <= cnt_nxt;
      o_left_lamp  <= left_lamp_nxt;
      o_right_lamp <= right_lamp_nxt;
      o_tick       <= enter_on;
      o_busy       <= (state_nxt != ST_IDLE);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_winker_blink_driver.sv
// ============================================================================
// Module   : tb_winker_blink_driver
// Purpose  : Directed self-checking bench for winker_blink_driver.
//            HALF_PERIOD is 4. A second instance with CNT_W=2 shares the
//            inputs, so counter saturation can be checked alongside.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_winker_blink_driver;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       left_req = 1'b0;
  logic       right_req = 1'b0;
  logic       left_lamp, right_lamp, tick, busy;
  logic [7:0] blink_cnt;
  logic       s_left_lamp, s_right_lamp, s_tick, s_busy;
  logic [1:0] s_blink_cnt;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  winker_blink_driver #(.HALF_PERIOD(4), .CNT_W(8)) u_dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_left_req   (left_req),
    .i_right_req  (right_req),
    .o_left_lamp  (left_lamp),
    .o_right_lamp (right_lamp),
    .o_tick       (tick),
    .o_blink_cnt  (blink_cnt),
    .o_busy       (busy)
  );

  winker_blink_driver #(.HALF_PERIOD(4), .CNT_W(2)) u_sat (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_left_req   (left_req),
    .i_right_req  (right_req),
    .o_left_lamp  (s_left_lamp),
    .o_right_lamp (s_right_lamp),
    .o_tick       (s_tick),
    .o_blink_cnt  (s_blink_cnt),
    .o_busy       (s_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic l, input logic r, input logic t,
                           input logic [7:0] c, input logic b);
    check({tag, ".left"},  {31'd0, left_lamp},  {31'd0, l});
    check({tag, ".right"}, {31'd0, right_lamp}, {31'd0, r});
    check({tag, ".tick"},  {31'd0, tick},       {31'd0, t});
    check({tag, ".cnt"},   {24'd0, blink_cnt},  {24'd0, c});
    check({tag, ".busy"},  {31'd0, busy},       {31'd0, b});
  endtask

  initial begin
    // Reset state
    #2;
    check_all("reset", 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    step();
    reset_n = 1'b1;
    step();
    check_all("idle", 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);

    // Left held: 4 on / 4 off, tick at each rise, count after each fall
    left_req = 1'b1;
    for (int i = 1; i <= 21; i++) begin
      step();
      check_all($sformatf("blink%0d", i), ((i - 1) % 8) < 4, 1'b0,
                ((i - 1) % 8) == 0, 8'((i + 3) / 8), 1'b1);
      check($sformatf("sat%0d", i), {30'd0, s_blink_cnt},
            ((i + 3) / 8) > 3 ? 32'd3 : 32'((i + 3) / 8));
    end
    // Drop during OFF: IDLE next edge, count holds
    left_req = 1'b0;
    step();
    check_all("drop_off", 1'b0, 1'b0, 1'b0, 8'd3, 1'b0);
    step();
    check_all("idle_hold", 1'b0, 1'b0, 1'b0, 8'd3, 1'b0);

    // Right dropped one cycle into ON
    right_req = 1'b1;
    step();
    check_all("r_on", 1'b0, 1'b1, 1'b1, 8'd0, 1'b1);
    right_req = 1'b0;
    for (int i = 2; i <= 4; i++) begin
      step();
      check_all($sformatf("r_hold%0d", i), 1'b0, 1'b1, 1'b0, 8'd0, 1'b1);
    end
    step();
    check_all("r_done", 1'b0, 1'b0, 1'b0, 8'd1, 1'b0);

    // Side change in OFF cycle 2
    left_req = 1'b1;
    for (int i = 1; i <= 6; i++) step();
    check_all("off2", 1'b0, 1'b0, 1'b0, 8'd1, 1'b1);
    left_req = 1'b0;
    right_req = 1'b1;
    step();
    check_all("switch", 1'b0, 1'b1, 1'b1, 8'd0, 1'b1);
    right_req = 1'b0;
    for (int i = 1; i <= 4; i++) step();
    check_all("switch_idle", 1'b0, 1'b0, 1'b0, 8'd1, 1'b0);

    // Both requests high from IDLE
    left_req = 1'b1;
    right_req = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
`ifdef WINKER_HAZARD_EN
      check_all($sformatf("both%0d", i), ((i - 1) % 8) < 4, ((i - 1) % 8) < 4,
                i == 1, 8'(i >= 5), 1'b1);
`else
      check_all($sformatf("both%0d", i), ((i - 1) % 8) < 4, 1'b0,
                i == 1, 8'(i >= 5), 1'b1);
`endif
    end
    left_req = 1'b0;
    right_req = 1'b0;
    step();
    check("both_idle.busy", {31'd0, busy}, 32'd0);

    // Latched right, then left joins
    right_req = 1'b1;
    step();
    check_all("r_latch", 1'b0, 1'b1, 1'b1, 8'd0, 1'b1);
    left_req = 1'b1;
    step();
`ifdef WINKER_HAZARD_EN
    check_all("r_to_both", 1'b1, 1'b1, 1'b1, 8'd0, 1'b1);
`else
    check_all("r_to_left", 1'b1, 1'b0, 1'b1, 8'd0, 1'b1);
`endif
    left_req = 1'b0;
    right_req = 1'b0;
    for (int i = 1; i <= 4; i++) step();
    check("change_idle.busy", {31'd0, busy}, 32'd0);

    // Reset in ON cycle 2
    left_req = 1'b1;
    step();
    step();
    check_all("on2", 1'b1, 1'b0, 1'b0, 8'd0, 1'b1);
    reset_n = 1'b0;
    #1;
    check_all("async_rst", 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    step();
    check_all("rst_held", 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    reset_n = 1'b1;
    step();
    check_all("post_rst", 1'b1, 1'b0, 1'b1, 8'd0, 1'b1);

    // 40 cycles held: 5 completed phases, CNT_W=2 saturates at 3
    for (int i = 2; i <= 40; i++) step();
    check("long.cnt", {24'd0, blink_cnt}, 32'd5);
    check("long.sat", {30'd0, s_blink_cnt}, 32'd3);
    left_req = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire
